// File: rtl/operand_sequencer.sv
// Operand entry sequencer: debounces the ENTER key and captures two 4-bit
// operands from SW in turn, flagging VALID once a complete pair is held.
module operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic       KEY_ENTER_N,
    input  logic [3:0] SW,
    output logic [3:0] OP_A,
    output logic [3:0] OP_B,
    output logic       VALID,
    output logic [2:0] LEDR
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic          sync_1;
    logic          sync_2;
    logic          db_level;
    logic          db_prev;
    logic [CW-1:0] db_cnt;
    logic          press;
    logic [1:0]    state;
    logic [1:0]    next_state;
    logic          load_a;
    logic          load_b;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= KEY_ENTER_N;
            sync_2 <= sync_1;
        end
    end

    // The level only moves after DEBOUNCE_CYCLES consecutive differing samples;
    // the counter clears on the switching edge so it can never wrap.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            db_level <= 1'b1;
            db_cnt   <= '0;
        end else if (sync_2 != db_level) begin
            if (db_cnt == CNT_MAX) begin
                db_level <= sync_2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            db_prev <= 1'b1;
        end else begin
            db_prev <= db_level;
        end
    end

    assign press = db_prev & ~db_level;

    always_comb begin
        next_state = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        if (press) begin
            case (state)
                S_A, S_DONE: begin
                    next_state = S_B;
                    load_a     = 1'b1;
                end
                S_B: begin
                    next_state = S_DONE;
                    load_b     = 1'b1;
                end
                default: next_state = S_A;
            endcase
        end else if (state == 2'd3) begin
            next_state = S_A;
        end
    end

    // VALID and LEDR are decoded from next_state so they change on the capture edge.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_A;
            OP_A  <= 4'd0;
            OP_B  <= 4'd0;
            VALID <= 1'b0;
            LEDR  <= 3'b001;
        end else begin
            state <= next_state;
            VALID <= (next_state == S_DONE);
            case (next_state)
                S_B:     LEDR <= 3'b010;
                S_DONE:  LEDR <= 3'b100;
                default: LEDR <= 3'b001;
            endcase
            if (load_a) begin
                OP_A <= SW;
                OP_B <= 4'd0;
            end
            if (load_b) begin
                OP_B <= SW;
            end
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: a sliding-window key model and a
// press-counting pair model are compared against the DUT every cycle.
module tb_operand_sequencer;

    localparam int DB = 4;

    logic       CLOCK_50;
    logic       RST_N;
    logic       KEY_ENTER_N;
    logic [3:0] SW;
    logic [3:0] OP_A;
    logic [3:0] OP_B;
    logic       VALID;
    logic [2:0] LEDR;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    logic       samp [0:DB+1];
    logic       m_db;
    bit         m_press_pending;
    int         m_stage;
    logic [3:0] m_a;
    logic [3:0] m_b;
    int         m_presses;

    operand_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
        .CLOCK_50    (CLOCK_50),
        .RST_N       (RST_N),
        .KEY_ENTER_N (KEY_ENTER_N),
        .SW          (SW),
        .OP_A        (OP_A),
        .OP_B        (OP_B),
        .VALID       (VALID),
        .LEDR        (LEDR)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The debounced level flips once the last DB synchronized samples (the raw key
    // two edges back) all disagree with it; a fall becomes a capture one edge later.
    always @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i <= DB + 1; i++) samp[i] = 1'b1;
            m_db            = 1'b1;
            m_press_pending = 0;
            m_stage         = 0;
            m_a             = 4'd0;
            m_b             = 4'd0;
        end else begin
            if (m_press_pending) begin
                m_presses++;
                if (m_stage == 1) begin
                    m_b     = SW;
                    m_stage = 2;
                end else begin
                    m_a     = SW;
                    m_b     = 4'd0;
                    m_stage = 1;
                end
            end
            m_press_pending = 0;
            for (int i = DB + 1; i >= 1; i--) samp[i] = samp[i-1];
            samp[0] = KEY_ENTER_N;
            begin
                bit all_diff;
                all_diff = 1;
                for (int i = 2; i <= DB + 1; i++) if (samp[i] == m_db) all_diff = 0;
                if (all_diff) begin
                    if (m_db && !samp[2]) m_press_pending = 1;
                    m_db = samp[2];
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (check_en) begin
            check_output("cyc_op_a",  {4'd0, OP_A}, {4'd0, m_a});
            check_output("cyc_op_b",  {4'd0, OP_B}, {4'd0, m_b});
            check_output("cyc_valid", {7'd0, VALID}, {7'd0, 1'(m_stage == 2)});
            check_output("cyc_ledr",  {5'd0, LEDR}, {5'd0, 3'(3'b001 << m_stage)});
        end
    end

    task automatic drive(input logic key, input logic [3:0] sw, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLOCK_50);
            #1;
            KEY_ENTER_N = key;
            SW          = sw;
        end
    endtask

    task automatic press(input logic [3:0] sw, input int hold);
        drive(1'b0, sw, hold);
        drive(1'b1, sw, 10);
    endtask

    // Holds the key low (already driven) and returns the posedge count at which OP_A becomes sw.
    task automatic measure_capture(input logic [3:0] sw, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (lat == 0 && OP_A == sw) lat = i;
        end
    endtask

    initial begin
        int lat;
        int presses_before;
        m_presses   = 0;
        RST_N       = 1'b1;
        KEY_ENTER_N = 1'b1;
        SW          = 4'd0;
        #2;
        RST_N = 1'b0;
        #1;
        check_en = 1;
        drive(1'b1, 4'd0, 3);
        check_output("rst_op_a",  {4'd0, OP_A}, 8'h00);
        check_output("rst_op_b",  {4'd0, OP_B}, 8'h00);
        check_output("rst_valid", {7'd0, VALID}, 8'h00);
        check_output("rst_ledr",  {5'd0, LEDR}, 8'h01);
        @(negedge CLOCK_50);
        #1;
        RST_N = 1'b1;
        drive(1'b1, 4'd0, 100);
        check_output("idle_ledr", {5'd0, LEDR}, 8'h01);
        check_output("idle_op_a", {4'd0, OP_A}, 8'h00);

        // Clean first press with latency measurement, then the second operand.
        drive(1'b0, 4'h9, 1);
        measure_capture(4'h9, lat);
        check_output("latency_a", 8'(lat), 8'd7);
        drive(1'b1, 4'h9, 10);
        check_output("a_op_a", {4'd0, OP_A}, 8'h09);
        check_output("a_op_b", {4'd0, OP_B}, 8'h00);
        check_output("a_ledr", {5'd0, LEDR}, 8'h02);
        press(4'h8, 8);
        check_output("b_op_b",  {4'd0, OP_B}, 8'h08);
        check_output("b_valid", {7'd0, VALID}, 8'h01);
        check_output("b_ledr",  {5'd0, LEDR}, 8'h04);

        press(4'h3, 8);
        check_output("redo_op_a",  {4'd0, OP_A}, 8'h03);
        check_output("redo_op_b",  {4'd0, OP_B}, 8'h00);
        check_output("redo_valid", {7'd0, VALID}, 8'h00);
        check_output("redo_ledr",  {5'd0, LEDR}, 8'h02);

        presses_before = m_presses;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h5, 2);
            drive(1'b1, 4'h5, 2);
        end
        press(4'h5, 15);
        check_output("bounce_model_presses", 8'(m_presses - presses_before), 8'd1);
        check_output("bounce_op_b", {4'd0, OP_B}, 8'h05);
        check_output("bounce_ledr", {5'd0, LEDR}, 8'h04);

        presses_before = m_presses;
        press(4'hC, 3);
        drive(1'b1, 4'hC, 10);
        check_output("glitch_model_presses", 8'(m_presses - presses_before), 8'd0);
        check_output("glitch_ledr", {5'd0, LEDR}, 8'h04);
        check_output("glitch_op_a", {4'd0, OP_A}, 8'h03);

        press(4'h6, 8);
        for (int v = 0; v < 16; v++) drive(1'b1, 4'(v), 1);
        check_output("sweep_op_a",  {4'd0, OP_A}, 8'h06);
        check_output("sweep_op_b",  {4'd0, OP_B}, 8'h00);
        check_output("sweep_valid", {7'd0, VALID}, 8'h00);
        check_output("sweep_ledr",  {5'd0, LEDR}, 8'h02);

        // Reset mid-debounce in S_B, key kept low across the reset.
        drive(1'b0, 4'hA, 3);
        @(negedge CLOCK_50);
        #1;
        RST_N = 1'b0;
        #1;
        check_output("midrst_op_a", {4'd0, OP_A}, 8'h00);
        check_output("midrst_ledr", {5'd0, LEDR}, 8'h01);
        drive(1'b0, 4'hA, 2);
        @(negedge CLOCK_50);
        #1;
        RST_N = 1'b1;
        measure_capture(4'hA, lat);
        check_output("latency_rst", 8'(lat), 8'd7);
        drive(1'b1, 4'hA, 10);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                @(negedge CLOCK_50);
                #1;
                RST_N = 1'b0;
                drive(KEY_ENTER_N, SW, $urandom_range(1, 2));
                @(negedge CLOCK_50);
                #1;
                RST_N = 1'b1;
            end else begin
                drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(1, 8));
            end
        end
        drive(1'b1, SW, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): number of consecutive stable cycles required before the debounced key level changes.
REQ-002 SHALL have port CLOCK_50 input 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N input 1: asynchronous, active-low reset.
REQ-004 SHALL have port KEY_ENTER_N input 1: raw push-button, low = pressed, asynchronous to CLOCK_50, bouncing.
REQ-005 SHALL have port SW input 4: operand value, quasi-static.
REQ-006 SHALL have port OP_A output 4: first captured operand, fed to the 4-bit adder/display stage.
REQ-007 SHALL have port OP_B output 4: second captured operand, fed to the 4-bit adder/display stage.
REQ-008 SHALL have port VALID output 1: high while OP_A and OP_B both hold a completed operand pair.
REQ-009 SHALL have port LEDR output 3: one-hot state indication; [0] = S_A, [1] = S_B, [2] = S_DONE.

Function
REQ-010 SHALL pass KEY_ENTER_N through a two-flop synchronizer, reset value 1, before any other use.
REQ-011 SHALL hold a debounced level, reset value 1 (released).
- Counter increments each cycle the synchronized input differs from the debounced level.
- Counter clears to 0 each cycle they are equal.
- When the counter reaches DEBOUNCE_CYCLES-1 while they still differ, the debounced level takes the synchronized value on that edge and the counter clears.
REQ-012 SHALL size the counter to $clog2(DEBOUNCE_CYCLES+1) bits; the counter SHALL never wrap.
REQ-013 SHALL generate a one-cycle internal press pulse on each debounced 1->0 transition; debounced 0->1 transitions (release) SHALL generate no event.
REQ-014 SHALL sample SW on the press-pulse cycle, with no further synchronization (switches are quasi-static).
REQ-015 SHALL implement the FSM S_A, S_B, S_DONE, with reset state S_A.
REQ-016 In S_A, a press SHALL load OP_A <= SW, clear OP_B to 0 and move to S_B.
REQ-017 In S_B, a press SHALL load OP_B <= SW and move to S_DONE.
REQ-018 In S_DONE, a press SHALL load OP_A <= SW, clear OP_B to 0, deassert VALID and move to S_B; a new pair is entered without returning to S_A.
REQ-019 With no press, state, OP_A and OP_B SHALL hold.
REQ-020 VALID SHALL be registered and high exactly while the state is S_DONE, asserting on the same edge that loads OP_B.
REQ-021 LEDR SHALL be a registered decode of the state, always exactly one-hot.
REQ-022 Press-to-capture latency SHALL be fixed, from the first low sample of KEY_ENTER_N held stable:
- 2 cycles synchronizer;
- plus DEBOUNCE_CYCLES cycles to update the debounced level;
- plus 1 cycle to register the capture.
REQ-023 A low pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no press.
REQ-024 Bounces of any length during a hold SHALL produce at most one press per debounced low level.
REQ-025 A key held indefinitely SHALL produce exactly one press.
REQ-026 SW changes while no press pulse is active SHALL not affect any output.

Reset
REQ-027 On RST_N low, asynchronously and regardless of state or debounce progress, the block SHALL force:
- state to S_A;
- OP_A = 0, OP_B = 0, VALID = 0, LEDR = 3'b001;
- synchronizer flops = 1, debounced level = 1, counter = 0.
REQ-028 After RST_N deasserts, a key already held low SHALL register as a press after the REQ-022 latency.
REQ-029 Reset asserted mid-debounce SHALL discard all partial count.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 Reset then idle: all outputs = 0 except LEDR = 001, stable for 100 cycles with KEY_ENTER_N = 1.
REQ-031 Full pair entry:
- SW=4'h9, clean press held 20 cycles, released -> OP_A=9, OP_B=0, LEDR=010, capture exactly 7 cycles after the key falls;
- then SW=4'h8, press -> OP_B=8, VALID=1, LEDR=100.
REQ-032 Bounce: key toggles low/high every 2 cycles for 12 cycles, then held low -> exactly one capture; a 3-cycle glitch alone -> no capture.
REQ-033 From S_DONE (A=9, B=8), SW=4'h3, press -> OP_A=3, OP_B=0, VALID=0, LEDR=010 on the same edge.
REQ-034 Reset in S_B with the key low mid-debounce -> immediate OP_A=0, LEDR=001; key still held after release of RST_N -> capture into OP_A 7 cycles later.
REQ-035 SW swept 0..F with no press in S_B -> OP_A, OP_B, VALID and LEDR unchanged.
